// File: rtl/fft_phase_sequencer.sv
`default_nettype none
// ============================================================================
// fft_phase_sequencer : phase/stage control sequencer for the FFT datapath.
// Optional macro FFT_SEQ_STALL_EN adds a stall input that freezes RUN.
// Revision: 1.0
// ============================================================================
module fft_phase_sequencer #(
   parameter int NUM_PHASES   = 4,
   parameter int PHASE_CYCLES = 1,
   parameter int NUM_STAGES   = 5,
   localparam int SEL_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
   localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk_100,
   input  logic                  reset_n,
   input  logic                  start,
`ifdef FFT_SEQ_STALL_EN
   input  logic                  stall,
`endif
   input  logic                  abort,
   output logic [NUM_PHASES-1:0] enable,
   output logic [SEL_W-1:0]      SEL,
   output logic [STAGE_W-1:0]    stage,
   output logic                  busy,
   output logic                  done
);

   localparam int DW_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [DW_W-1:0]    DW_LAST = DW_W'(PHASE_CYCLES - 1);
   localparam logic [SEL_W-1:0]   PH_LAST = SEL_W'(NUM_PHASES - 1);
   localparam logic [STAGE_W-1:0] ST_LAST = STAGE_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DW_W-1:0]      dwell_q, dwell_d;
   logic [SEL_W-1:0]     phase_q, phase_d;
   logic [STAGE_W-1:0]   stage_q, stage_d;
   logic [NUM_PHASES-1:0] enable_q, enable_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 hold_run;
   logic                 bad_count;

`ifdef FFT_SEQ_STALL_EN
   assign hold_run = stall;
`else
   assign hold_run = 1'b0;
`endif

   // Out-of-range counter encodings are treated as corruption and drop to IDLE.
   assign bad_count = (32'(phase_q) >= 32'(NUM_PHASES)) ||
                      (32'(stage_q) >= 32'(NUM_STAGES));

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      phase_d = phase_q;
      stage_d = stage_q;
      case (state_q)
         S_IDLE: begin
            dwell_d = '0;
            phase_d = '0;
            stage_d = '0;
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort || bad_count) begin
               state_d = S_IDLE;
               dwell_d = '0;
               phase_d = '0;
               stage_d = '0;
            end else if (!hold_run) begin
               if (dwell_q != DW_LAST) begin
                  dwell_d = dwell_q + DW_W'(1);
               end else begin
                  dwell_d = '0;
                  if (phase_q != PH_LAST) begin
                     phase_d = phase_q + SEL_W'(1);
                  end else begin
                     phase_d = '0;
                     if (stage_q != ST_LAST) begin
                        stage_d = stage_q + STAGE_W'(1);
                     end else begin
                        stage_d = '0;
                        state_d = S_DONE;
                     end
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            dwell_d = '0;
            phase_d = '0;
            stage_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            dwell_d = '0;
            phase_d = '0;
            stage_d = '0;
         end
      endcase
   end

   // Outputs are derived from the next state so they register in step with it.
   always_comb begin
      enable_d = '0;
      if (state_d == S_RUN) begin
         enable_d = NUM_PHASES'(1) << phase_d;
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         dwell_q  <= '0;
         phase_q  <= '0;
         stage_q  <= '0;
         enable_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dwell_q  <= dwell_d;
         phase_q  <= phase_d;
         stage_q  <= stage_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign enable = enable_q;
   assign SEL    = phase_q;
   assign stage  = stage_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_phase_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fft_phase_sequencer : self-checking bench, default and PHASE_CYCLES=3 units.
// Revision: 1.0
// ============================================================================
module tb_fft_phase_sequencer;

   typedef struct packed {
      logic [3:0] en;
      logic [1:0] sel;
      logic [2:0] stg;
      logic       busy;
      logic       done;
   } exp_t;

   typedef struct {
      logic start;
      logic abort;
      exp_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       start_b = 1'b0;
`ifdef FFT_SEQ_STALL_EN
   logic       stall = 1'b0;
`endif
   logic [3:0] en_a, en_b;
   logic [1:0] sel_a, sel_b;
   logic [2:0] stg_a, stg_b;
   logic       busy_a, busy_b, done_a, done_b;

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q[$];
   vec_t tbl[22];

   always #5 clk = ~clk;

   fft_phase_sequencer u_dut_a (
      .clk_100 (clk),
      .reset_n (reset_n),
      .start   (start),
`ifdef FFT_SEQ_STALL_EN
      .stall   (stall),
`endif
      .abort   (abort),
      .enable  (en_a),
      .SEL     (sel_a),
      .stage   (stg_a),
      .busy    (busy_a),
      .done    (done_a)
   );

   fft_phase_sequencer #(.PHASE_CYCLES(3)) u_dut_b (
      .clk_100 (clk),
      .reset_n (reset_n),
      .start   (start_b),
`ifdef FFT_SEQ_STALL_EN
      .stall   (1'b0),
`endif
      .abort   (1'b0),
      .enable  (en_b),
      .SEL     (sel_b),
      .stage   (stg_b),
      .busy    (busy_b),
      .done    (done_b)
   );

   function automatic exp_t exp_run(input int k, input int pc);
      exp_t e;
      int   ph;
      ph = (k / pc) % 4;
      e.en = 4'b0001 << ph;
      e.sel = 2'(ph);
      e.stg = 3'(k / (pc * 4));
      e.busy = 1'b1;
      e.done = 1'b0;
      return e;
   endfunction

   function automatic exp_t exp_idle();
      return '0;
   endfunction

   function automatic exp_t exp_done();
      exp_t e;
      e = '0;
      e.done = 1'b1;
      return e;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got en=%b sel=%0d stage=%0d busy=%b done=%b, expected en=%b sel=%0d stage=%0d busy=%b done=%b",
                  name, act.en, act.sel, act.stg, act.busy, act.done,
                  exp.en, exp.sel, exp.stg, exp.busy, exp.done);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_a(input logic s, input logic a, input exp_t e, input string name);
      start = s;
      abort = a;
      q.push_back(e);
      tick();
      check(name, {en_a, sel_a, stg_a, busy_a, done_a}, q.pop_front());
   endtask

   task automatic cyc_b(input logic s, input exp_t e, input string name);
      start_b = s;
      q.push_back(e);
      tick();
      check(name, {en_b, sel_b, stg_b, busy_b, done_b}, q.pop_front());
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < 22; i++) begin
         cyc_a(tbl[i].start, tbl[i].abort, tbl[i].exp, $sformatf("%s[%0d]", name, i));
      end
   endtask

   initial begin
      // Full frame; start/abort pulses in RUN, DONE and IDLE probe the ignore rules.
      for (int i = 0; i < 22; i++) begin
         tbl[i].start = (i == 0) || (i == 10) || (i == 21);
         tbl[i].abort = (i == 0) || (i == 21);
         tbl[i].exp   = (i < 20) ? exp_run(i, 1) : ((i == 20) ? exp_done() : exp_idle());
      end

      repeat (3) tick();
      check("reset_a", {en_a, sel_a, stg_a, busy_a, done_a}, exp_idle());
      check("reset_b", {en_b, sel_b, stg_b, busy_b, done_b}, exp_idle());
      reset_n = 1'b1;
      cyc_a(1'b0, 1'b0, exp_idle(), "idle_after_reset");

      run_table("frame");
      cyc_a(1'b0, 1'b0, exp_idle(), "idle_gap");

      for (int k = 0; k < 8; k++) cyc_a(k == 0, 1'b0, exp_run(k, 1), $sformatf("pre_abort[%0d]", k));
      cyc_a(1'b0, 1'b1, exp_idle(), "abort");
      for (int k = 0; k < 3; k++) cyc_a(1'b0, 1'b0, exp_idle(), "post_abort_no_done");
      run_table("frame_after_abort");

      for (int k = 0; k < 10; k++) cyc_a(1'b1, 1'b0, exp_run(k, 1), $sformatf("pre_reset[%0d]", k));
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", {en_a, sel_a, stg_a, busy_a, done_a}, exp_idle());
      start = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
      check("after_async_reset", {en_a, sel_a, stg_a, busy_a, done_a}, exp_idle());

      // start held high: RUN, DONE, IDLE, RUN again with no restart mid-frame.
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 20; k++) cyc_a(1'b1, 1'b0, exp_run(k, 1), $sformatf("b2b%0d[%0d]", f, k));
         cyc_a(1'b1, 1'b0, exp_done(), "b2b_done");
         cyc_a(1'b1, 1'b0, exp_idle(), "b2b_gap");
      end
      cyc_a(1'b1, 1'b0, exp_run(0, 1), "b2b_restart");
      start = 1'b0;
      for (int k = 1; k < 20; k++) cyc_a(1'b0, 1'b0, exp_run(k, 1), "b2b_tail");
      cyc_a(1'b0, 1'b0, exp_done(), "b2b_tail_done");
      cyc_a(1'b0, 1'b0, exp_idle(), "b2b_tail_idle");

      for (int k = 0; k < 60; k++) cyc_b(k == 0, exp_run(k, 3), $sformatf("pc3[%0d]", k));
      cyc_b(1'b0, exp_done(), "pc3_done");
      cyc_b(1'b0, exp_idle(), "pc3_idle");

`ifdef FFT_SEQ_STALL_EN
      for (int k = 0; k < 3; k++) cyc_a(k == 0, 1'b0, exp_run(k, 1), "pre_stall");
      stall = 1'b1;
      for (int k = 0; k < 4; k++) cyc_a(1'b0, 1'b0, exp_run(2, 1), "stall_hold");
      stall = 1'b0;
      for (int k = 3; k < 20; k++) cyc_a(1'b0, 1'b0, exp_run(k, 1), "post_stall");
      cyc_a(1'b0, 1'b0, exp_done(), "stall_done");
      cyc_a(1'b0, 1'b0, exp_idle(), "stall_idle");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
